// File: rtl/counter_pkg.sv
// Shared types and direction constants for the up/down counter family.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr wins over inc.
module sat_event_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_reg <= '0;
    end else if (inc && !(&value_reg)) begin
      value_reg <= value_reg + WIDTH'(1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo (limit+1) up/down counter with wrap or saturate behaviour at the ends,
// a registered wrap strobe and a saturating count of wrap events.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OVF_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 enable,
  input  logic                 up_dn,
  input  cnt_mode_e            mode,
  input  logic [WIDTH-1:0]     limit,
  input  logic [WIDTH-1:0]     start_val,
  input  logic                 clr_ovf,
  output logic [WIDTH-1:0]     count,
  output logic                 at_max,
  output logic                 at_min,
  output logic                 wrap_pulse,
  output logic [OVF_WIDTH-1:0] ovf_count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_pulse_reg;
  logic             wrap_evt;

  always_comb begin
    count_next = count_reg;
    wrap_evt   = 1'b0;
    if (load) begin
      count_next = (start_val > limit) ? limit : start_val;
    end else if (enable) begin
      if (up_dn == UP) begin
        // Increment only below limit, so count+1 can never exceed the register range.
        if (count_reg < limit) begin
          count_next = count_reg + WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          count_next = '0;
          wrap_evt   = 1'b1;
        end else begin
          count_next = limit;
        end
      end else begin
        // A count stranded above a lowered limit snaps back without a wrap.
        if (count_reg > limit) begin
          count_next = limit;
        end else if (count_reg != '0) begin
          count_next = count_reg - WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          count_next = limit;
          wrap_evt   = 1'b1;
        end else begin
          count_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      wrap_pulse_reg <= 1'b0;
    end else begin
      count_reg      <= count_next;
      wrap_pulse_reg <= wrap_evt;
    end
  end

  sat_event_counter #(
    .WIDTH (OVF_WIDTH)
  ) u_ovf_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_ovf),
    .inc   (wrap_evt),
    .value (ovf_count)
  );

  assign count      = count_reg;
  assign wrap_pulse = wrap_pulse_reg;
  assign at_max     = (count_reg == limit);
  assign at_min     = (count_reg == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed scenarios plus randomized traffic against an integer reference model.
module tb_mod_updown_counter;
  import counter_pkg::*;

  localparam int W     = 8;
  localparam int OW    = 4;
  localparam int OVMAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst, load, enable, up_dn, clr_ovf;
  cnt_mode_e     mode;
  logic [W-1:0]  limit, start_val, count;
  logic          at_max, at_min, wrap_pulse;
  logic [OW-1:0] ovf_count;

  int m_cnt, m_wp, m_ovf;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .OVF_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .enable     (enable),
    .up_dn      (up_dn),
    .mode       (mode),
    .limit      (limit),
    .start_val  (start_val),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .wrap_pulse (wrap_pulse),
    .ovf_count  (ovf_count)
  );

  // Advance the reference model from the current inputs, then let the DUT take the edge.
  task automatic tick();
    int lim, ev;
    lim = int'(limit);
    ev  = 0;
    if (rst) begin
      m_cnt = 0; m_wp = 0; m_ovf = 0;
    end else begin
      if (load) begin
        m_cnt = (int'(start_val) < lim) ? int'(start_val) : lim;
      end else if (enable) begin
        if (up_dn == UP) begin
          if (m_cnt < lim) m_cnt = m_cnt + 1;
          else if (mode == MODE_WRAP) begin m_cnt = 0; ev = 1; end
          else m_cnt = lim;
        end else begin
          if (m_cnt > lim) m_cnt = lim;
          else if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (mode == MODE_WRAP) begin m_cnt = lim; ev = 1; end
          else m_cnt = 0;
        end
      end
      m_wp = ev;
      if (clr_ovf) m_ovf = 0;
      else if (ev != 0 && m_ovf < OVMAX) m_ovf = m_ovf + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; enable = 1'b0; up_dn = UP; clr_ovf = 1'b0;
    mode = MODE_WRAP; start_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; load = 1'b1; enable = 1'b1; clr_ovf = 1'b1; start_val = 8'd77; limit = 8'd0;
    tick();
    tick();
    rst = 1'b0; load = 1'b0; enable = 1'b0; clr_ovf = 1'b0;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap_pulse); end
    n_cmp++; if (ovf_count !== 4'd0) begin n_bad++; $display("FAIL reset_ovf got %0d want 0", ovf_count); end
    n_cmp++; if (at_min !== 1'b1) begin n_bad++; $display("FAIL reset_at_min got %b want 1", at_min); end
    n_cmp++; if (at_max !== 1'b1) begin n_bad++; $display("FAIL reset_at_max_lim0 got %b want 1", at_max); end
    limit = 8'd5;
    #1;
    n_cmp++; if (at_max !== 1'b0) begin n_bad++; $display("FAIL reset_at_max_lim5 got %b want 0", at_max); end
    $display("test_reset: count=%0d wrap=%b ovf=%0d", count, wrap_pulse, ovf_count);
  endtask

  task automatic test_wrap_up();
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int highs = 0;
    limit = 8'd9;
    do_reset();
    mode = MODE_WRAP; up_dn = UP; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wrap_pulse === 1'b1) highs++;
      n_cmp++; if (count !== 8'(exp_seq[i])) begin n_bad++; $display("FAIL wrap_up_count[%0d] got %0d want %0d", i, count, exp_seq[i]); end
      n_cmp++; if (wrap_pulse !== (i == 9)) begin n_bad++; $display("FAIL wrap_up_pulse[%0d] got %b want %b", i, wrap_pulse, (i == 9)); end
      $display("test_wrap_up: cycle=%0d count=%0d wrap=%b", i, count, wrap_pulse);
    end
    enable = 1'b0;
    n_cmp++; if (highs != 1) begin n_bad++; $display("FAIL wrap_up_highs got %0d want 1", highs); end
    n_cmp++; if (ovf_count !== 4'd1) begin n_bad++; $display("FAIL wrap_up_ovf got %0d want 1", ovf_count); end
  endtask

  task automatic test_sat_down();
    int exp_seq[4] = '{1, 0, 0, 0};
    limit = 8'd9;
    do_reset();
    mode = MODE_SAT; load = 1'b1; start_val = 8'd2;
    tick();
    load = 1'b0;
    n_cmp++; if (count !== 8'd2) begin n_bad++; $display("FAIL sat_load got %0d want 2", count); end
    enable = 1'b1; up_dn = DN;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (count !== 8'(exp_seq[i])) begin n_bad++; $display("FAIL sat_down_count[%0d] got %0d want %0d", i, count, exp_seq[i]); end
      n_cmp++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL sat_down_pulse[%0d] got %b want 0", i, wrap_pulse); end
      n_cmp++; if (at_min !== (i >= 1)) begin n_bad++; $display("FAIL sat_down_at_min[%0d] got %b want %b", i, at_min, (i >= 1)); end
      $display("test_sat_down: cycle=%0d count=%0d at_min=%b", i, count, at_min);
    end
    enable = 1'b0;
  endtask

  task automatic test_load_clamp();
    limit = 8'd5;
    do_reset();
    load = 1'b1; start_val = 8'd200;
    tick();
    load = 1'b0;
    n_cmp++; if (count !== 8'd5) begin n_bad++; $display("FAIL clamp_count got %0d want 5", count); end
    n_cmp++; if (at_max !== 1'b1) begin n_bad++; $display("FAIL clamp_at_max got %b want 1", at_max); end
    $display("test_load_clamp: loaded count=%0d at_max=%b", count, at_max);
    enable = 1'b1; up_dn = DN; mode = MODE_WRAP; limit = 8'd3;
    tick();
    enable = 1'b0;
    n_cmp++; if (count !== 8'd3) begin n_bad++; $display("FAIL lowered_limit_count got %0d want 3", count); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL lowered_limit_pulse got %b want 0", wrap_pulse); end
    $display("test_load_clamp: after lowered limit count=%0d wrap=%b", count, wrap_pulse);
  endtask

  task automatic test_limit_zero();
    int exp_ovf;
    limit = 8'd0;
    do_reset();
    mode = MODE_WRAP; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      up_dn = (i % 3 == 0) ? DN : UP;
      tick();
      exp_ovf = (i + 1 < OVMAX) ? i + 1 : OVMAX;
      n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL lim0_count[%0d] got %0d want 0", i, count); end
      n_cmp++; if (wrap_pulse !== 1'b1) begin n_bad++; $display("FAIL lim0_pulse[%0d] got %b want 1", i, wrap_pulse); end
      n_cmp++; if (ovf_count !== 4'(exp_ovf)) begin n_bad++; $display("FAIL lim0_ovf[%0d] got %0d want %0d", i, ovf_count, exp_ovf); end
      $display("test_limit_zero: cycle=%0d count=%0d wrap=%b ovf=%0d", i, count, wrap_pulse, ovf_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_clr_ovf();
    limit = 8'd0;
    do_reset();
    mode = MODE_WRAP; enable = 1'b1; up_dn = UP;
    repeat (7) tick();
    n_cmp++; if (ovf_count !== 4'd7) begin n_bad++; $display("FAIL clr_pre_ovf got %0d want 7", ovf_count); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0; enable = 1'b0;
    n_cmp++; if (ovf_count !== 4'd0) begin n_bad++; $display("FAIL clr_ovf got %0d want 0", ovf_count); end
    n_cmp++; if (wrap_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_pulse got %b want 1", wrap_pulse); end
    $display("test_clr_ovf: ovf=%0d wrap=%b", ovf_count, wrap_pulse);
  endtask

  task automatic test_reset_priority();
    limit = 8'd0;
    do_reset();
    mode = MODE_WRAP; up_dn = UP; enable = 1'b1;
    repeat (2) tick();
    limit = 8'd9;
    repeat (4) tick();
    n_cmp++; if (count !== 8'd4 || ovf_count !== 4'd2) begin
      n_bad++; $display("FAIL prio_setup got count=%0d ovf=%0d want count=4 ovf=2", count, ovf_count);
    end
    rst = 1'b1; load = 1'b1; start_val = 8'd7; clr_ovf = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0; enable = 1'b0; clr_ovf = 1'b0;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL prio_count got %0d want 0", count); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL prio_pulse got %b want 0", wrap_pulse); end
    n_cmp++; if (ovf_count !== 4'd0) begin n_bad++; $display("FAIL prio_ovf got %0d want 0", ovf_count); end
    $display("test_reset_priority: count=%0d wrap=%b ovf=%0d", count, wrap_pulse, ovf_count);
  endtask

  task automatic test_random();
    limit = 8'd6;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      load    = ($urandom_range(0, 9) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      up_dn   = ($urandom_range(0, 2) != 0) ? UP : DN;
      clr_ovf = ($urandom_range(0, 29) == 0);
      mode    = cnt_mode_e'($urandom_range(0, 1));
      start_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0)
        limit = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      tick();
      n_cmp++;
      if (count !== 8'(m_cnt) || wrap_pulse !== (m_wp != 0) || ovf_count !== 4'(m_ovf) ||
          at_max !== (m_cnt == int'(limit)) || at_min !== (m_cnt == 0)) begin
        n_bad++;
        $display("FAIL random[%0d] got cnt=%0d wp=%b ovf=%0d max=%b min=%b want cnt=%0d wp=%0d ovf=%0d max=%b min=%b",
                 i, count, wrap_pulse, ovf_count, at_max, at_min,
                 m_cnt, m_wp, m_ovf, (m_cnt == int'(limit)), (m_cnt == 0));
      end
      $display("test_random: cycle=%0d lim=%0d count=%0d wrap=%b ovf=%0d", i, limit, count, wrap_pulse, ovf_count);
    end
  endtask

  initial begin
    idle_inputs();
    limit = '0;
    m_cnt = 0; m_wp = 0; m_ovf = 0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_limit_zero();
    test_clr_ovf();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
